mw_wdata_pipe: RTL

- Parametrised M-stage write-data selector fused with the M/W pipeline register for the pipelined MIPS CPU.
- Selects GRF write data from NSRC flattened sources and applies the link offset to the link source.
- Waits on one multi-cycle source (load/mul-div result) with a valid handshake, requesting a pipeline stall until the data arrives or a timeout fires.
- Registers the selected data, write address and write enable into the W stage, and exports the unregistered M-stage value for forwarding.

---
 rtl/mw_wdata_pipe.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mw_wdata_pipe.sv
// M-stage GRF write-data select fused with the M/W pipeline register; 1 cycle (slow source: k+1).
// Stalls via stall_req while the slow source is pending; optional trace with WDATA_TRACE_EN.
module mw_wdata_pipe #(
  parameter int WIDTH       = 32,
  parameter int NSRC        = 4,
  parameter int SEL_W       = 2,
  parameter int LINK_SEL    = 2,
  parameter int LINK_OFFSET = 4,
  parameter int SLOW_SEL    = 3,
  parameter int TIMEOUT     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m_valid,
  input  logic [NSRC*WIDTH-1:0] m_src,
  input  logic [SEL_W-1:0]      m_sel,
  input  logic [4:0]            m_wa,
  input  logic                  m_we,
  input  logic [31:0]           m_pc,
  input  logic [WIDTH-1:0]      slow_data,
  input  logic                  slow_valid,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic                  stall_req,
  output logic [WIDTH-1:0]      m_fwd_data,
  output logic [WIDTH-1:0]      w_wdata,
  output logic [4:0]            w_wa,
  output logic                  w_we,
  output logic [31:0]           w_pc,
  output logic                  w_valid,
  output logic                  timeout_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] commit_data;
  logic             slow_op;
  logic             timeout_hit;
  logic             load_we;

  always_comb begin
    sel = m_sel;
    if (int'(m_sel) >= NSRC) sel = '0;
    sel_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (int'(sel) == i) sel_data = m_src[i*WIDTH +: WIDTH];
    end
    if (int'(sel) == SLOW_SEL) sel_data = slow_data;
    if (int'(sel) == LINK_SEL) sel_data = sel_data + WIDTH'(LINK_OFFSET);
  end

  assign m_fwd_data  = sel_data;
  assign slow_op     = m_valid & ~flush & (int'(sel) == SLOW_SEL);
  assign timeout_hit = (state == ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign stall_req   = slow_op & ~slow_valid & ~timeout_hit;
  // An aborted slow op still retires, but with zero data.
  assign commit_data = (slow_op & ~slow_valid & timeout_hit) ? '0 : sel_data;
  assign load_we     = m_valid & m_we & (m_wa != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (flush) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else if (!stall_in) begin
      case (state)
        ST_IDLE: begin
          if (slow_op && !slow_valid) begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (!slow_op || slow_valid) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_valid <= 1'b0;
      w_we    <= 1'b0;
      w_wa    <= '0;
      w_wdata <= '0;
      w_pc    <= '0;
    end else if (flush || (!stall_in && stall_req)) begin
      w_valid <= 1'b0;
      w_we    <= 1'b0;
      w_wa    <= '0;
      w_wdata <= '0;
      w_pc    <= '0;
    end else if (!stall_in) begin
      w_valid <= m_valid;
      w_we    <= load_we;
      w_wa    <= m_wa;
      w_wdata <= commit_data;
      w_pc    <= m_pc;
    end
  end

`ifdef WDATA_TRACE_EN
  always @(posedge clk) begin
    if (!reset && !flush && !stall_in && !stall_req && load_we)
      $display("%d@%h: $%d <= %h", $time, m_pc, m_wa, commit_data);
  end
`endif

endmodule
